// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path types and constants
package cpu_pkg;

   localparam logic [31:0] INST_NOP   = 32'h0000_0000;
   localparam int          WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetched {pc, inst} pairs
// Flush outranks push and pop; the head is read straight from storage.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - credit-based instruction prefetcher feeding IF/ID
// Tracks fetch/response PCs, outstanding requests and stale responses to drop after a redirect.
module fetch_prefetch_unit
   import cpu_pkg::*;
#(
   parameter int                 DEPTH    = 4,
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [31:0]       imem_resp_data,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [31:0]       if_inst
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   fetch_entry_t      fifo_head;
   fetch_entry_t      push_entry;
   logic [CW:0]       credit_used;
   logic [ADDR_W-1:0] redirect_aligned;
   logic              req_fire;
   logic              resp_ok;
   logic              push;
   logic              pop;

   assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign imem_req_valid   = !reset && (credit_used < (CW+1)'(DEPTH)) && !redirect;
   assign imem_req_addr    = fetch_pc_q;
   assign req_fire         = imem_req_valid && imem_req_ready;
   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

   // Untracked responses (outstanding already zero) are ignored so counters never wrap.
   assign resp_ok    = imem_resp_valid && (outstanding_q != '0);
   assign push       = resp_ok && !redirect && (drop_cnt_q == '0);
   assign pop        = if_valid && !stall && !redirect;
   assign push_entry = '{pc: 32'(resp_pc_q), inst: imem_resp_data};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
      if (redirect) begin
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
         drop_cnt_d = outstanding_q - CW'(resp_ok);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_BYTES);
         end
         if (resp_ok) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - 1'b1;
            end else begin
               resp_pc_d = resp_pc_q + ADDR_W'(WORD_BYTES);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign if_valid = !fifo_empty;
   assign if_pc    = fifo_empty ? '0 : ADDR_W'(fifo_head.pc);
   assign if_inst  = fifo_empty ? INST_NOP : fifo_head.inst;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && fifo_full && !pop));
   a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
      !(imem_resp_valid && outstanding_q == '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_inst         (if_inst)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] addr; logic stale; } tok_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct {
      logic        exp_if_valid;
      logic [31:0] exp_if_pc;
      logic        exp_req_valid;
      logic [31:0] exp_req_addr;
   } vec_t;

   mreq_t mem_q[$];
   tok_t  inflight[$];
   ent_t  efifo[$];
   logic [31:0] exp_pc = RESET_PC;
   int    lat = 1;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   string phase = "init";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%s] cycle %0d: got %h expected %h", name, phase, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, let the memory answer, compare with the model, advance the model.
   task automatic step(input logic rst, input logic stl, input logic rdr,
                       input logic [31:0] rpc, input logic rdy);
      logic exp_rv;
      logic do_pop;
      tok_t tok;
      @(negedge clk);
      reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc; imem_req_ready = rdy;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (rst) begin
         mem_q.delete();
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_q[0].addr ^ KEY;
         void'(mem_q.pop_front());
      end
      #1;
      exp_rv = !rst && !rdr && (efifo.size() + inflight.size() < DEPTH);
      chk("if_valid", 32'(if_valid), 32'(efifo.size() > 0));
      chk("if_pc",   if_pc,   efifo.size() > 0 ? efifo[0].pc   : 32'h0);
      chk("if_inst", if_inst, efifo.size() > 0 ? efifo[0].inst : 32'h0);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
      if (!rst && imem_req_valid && rdy) mem_q.push_back('{imem_req_addr, cyc + lat});
      if (rst) begin
         efifo.delete();
         inflight.delete();
         exp_pc = RESET_PC;
      end else begin
         do_pop = (efifo.size() > 0) && !stl && !rdr;
         if (do_pop) void'(efifo.pop_front());
         if (imem_resp_valid) begin
            chk("resp_tracked", 32'(inflight.size() > 0), 32'h1);
            if (inflight.size() > 0) begin
               tok = inflight.pop_front();
               if (!rdr && !tok.stale) efifo.push_back('{tok.addr, tok.addr ^ KEY});
            end
         end
         if (rdr) begin
            efifo.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            exp_pc = rpc & ~32'h3;
         end else if (exp_rv && rdy) begin
            inflight.push_back('{exp_pc, 1'b0});
            exp_pc = exp_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic do_reset(input int new_lat);
      lat = new_lat;
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   vec_t tbl[6];
   logic [31:0] held_pc, held_inst, last_pop, next_acc;
   logic        have_pop, found;
   logic        rp[4];

   initial begin
      tbl[0] = '{1'b0, 32'h0, 1'b1, 32'h00};
      tbl[1] = '{1'b0, 32'h0, 1'b1, 32'h04};
      tbl[2] = '{1'b1, 32'h0, 1'b1, 32'h08};
      tbl[3] = '{1'b1, 32'h4, 1'b1, 32'h0C};
      tbl[4] = '{1'b1, 32'h8, 1'b1, 32'h10};
      tbl[5] = '{1'b1, 32'hC, 1'b1, 32'h14};

      phase = "reset_stream";
      do_reset(1);
      have_pop = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         chk("tbl_if_valid", 32'(if_valid), 32'(tbl[i].exp_if_valid));
         chk("tbl_if_pc", if_pc, tbl[i].exp_if_pc);
         chk("tbl_if_inst", if_inst, tbl[i].exp_if_valid ? (tbl[i].exp_if_pc ^ KEY) : 32'h0);
         chk("tbl_req_valid", 32'(imem_req_valid), 32'(tbl[i].exp_req_valid));
         chk("tbl_req_addr", imem_req_addr, tbl[i].exp_req_addr);
         if (if_valid) begin
            if (have_pop) chk("seq_pop", if_pc, last_pop + 32'd4);
            last_pop = if_pc; have_pop = 1'b1;
         end
      end

      phase = "stall_hold";
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
         if (i == 0) begin
            held_pc = if_pc; held_inst = if_inst;
         end else begin
            chk("stall_pc", if_pc, held_pc);
            chk("stall_inst", if_inst, held_inst);
         end
      end
      chk("stall_credit_block", 32'(imem_req_valid), 32'h0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         if (if_valid) begin
            chk("seq_pop", if_pc, last_pop + 32'd4);
            last_pop = if_pc;
         end
      end

      phase = "redirect_inflight";
      do_reset(3);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
      chk("redir_no_req", 32'(imem_req_valid), 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("redir_req_valid", 32'(imem_req_valid), 32'h1);
      chk("redir_req_addr", imem_req_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         if (!found && if_valid) begin
            found = 1'b1;
            chk("redir_first_pc", if_pc, 32'h100);
         end
      end
      chk("redir_delivered", 32'(found), 32'h1);

      phase = "redirect_on_resp";
      do_reset(2);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
      chk("edge_resp_present", 32'(imem_resp_valid), 32'h1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("edge_drop_cnt", 32'(dut.drop_cnt_q), 32'h1);
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         if (!found && if_valid) begin
            found = 1'b1;
            chk("edge_first_pc", if_pc, 32'h40);
         end
      end
      chk("edge_delivered", 32'(found), 32'h1);

      phase = "backpressure";
      do_reset(1);
      rp[0] = 1'b1; rp[1] = 1'b0; rp[2] = 1'b0; rp[3] = 1'b1;
      next_acc = RESET_PC;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, rp[i % 4]);
         if (imem_req_valid) begin
            chk("bp_addr", imem_req_addr, next_acc);
            if (rp[i % 4]) next_acc = next_acc + 32'd4;
         end
      end

      phase = "midrun_reset";
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("full_before_reset", 32'(dut.u_fifo.full), 32'h1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("post_rst_if_valid", 32'(if_valid), 32'h0);
      chk("post_rst_if_inst", if_inst, 32'h0);
      chk("post_rst_req_addr", imem_req_addr, RESET_PC);

      phase = "random";
      for (int seg = 0; seg < 4; seg++) begin
         do_reset(int'($urandom_range(1, 3)));
         for (int i = 0; i < 600; i++) begin
            logic r_rst, r_stl, r_rdr, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_rdr = ($urandom_range(0, 11) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom();
            step(r_rst, r_stl, r_rdr, r_pc, r_rdy);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
